interconnect_packet_sender: RTL and testbench
=============================================

// Module: interconnect_packet_sender
// PURPOSE
//  Initiator for the interconnect packet port: collects PACKET_SIZE 32-bit words from a local producer.
//  Issues one packet (send pulse + word burst) toward the interconnect router.
//  Waits for the router's route_ready/route_error pulse and reports the completion status upstream.
//  Sits between the local bus master and the interconnect host's src_addr/dest_addr/packet_data/packet_send inputs.
// PARAMETERS
//  PACKET_SIZE     8     words per packet (>=2, power of 2)
//  TIMEOUT_CYCLES  64    max cycles in WAIT_RESP before timeout completion
//  MAX_RETRY       3     resend attempts after route_error (only with IC_SENDER_RETRY_EN)
// PORTS
//  clk           in   1   single clock, all state on rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  load_valid    in   1   producer word valid
//  load_ready    out  1   buffer accepts a word (transfer when valid&ready)
//  load_data     in   32  producer word
//  tx_start      in   1   start transmission of buffered packet
//  tx_src_addr   in   32  source address, captured on accepted tx_start
//  tx_dest_addr  in   32  destination address, captured on accepted tx_start
//  tx_busy       out  1   high from accepted tx_start until done pulse
//  packet_send   out  1   one-cycle packet start strobe to router
//  src_addr      out  32  held source address
//  dest_addr     out  32  held destination address
//  packet_data   out  32  packet word stream
//  route_ready   in   1   router success pulse
//  route_error   in   1   router failure pulse
//  routed_addr   in   32  router result address, valid with route_ready
//  routed_data   in   32  router result data, valid with route_ready
//  done          out  1   one-cycle completion pulse
//  done_status   out  2   00 ok, 01 route error, 10 timeout; held until next done
//  resp_addr     out  32  captured routed_addr on success
//  resp_data     out  32  captured routed_data on success
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, buffer count 0, retry count 0, load_ready=1 after reset release.
//  States: IDLE -> START -> BURST -> WAIT_RESP -> DONE -> IDLE.
//  IDLE: load_ready = (count<PACKET_SIZE); each transfer writes buf[wptr], wptr/count+1.
//    tx_start accepted only when count==PACKET_SIZE; otherwise ignored, no status.
//    Load and tx_start in the same cycle: only the load completes (count not yet full).
//  START: packet_send=1 for exactly 1 cycle, packet_data=buf[0]; src_addr/dest_addr held stable through DONE.
//  BURST: PACKET_SIZE cycles, packet_data=buf[i] for i=0..PACKET_SIZE-1, packet_send=0; load_ready=0.
//    Router samples the word on the cycle after the strobe, so word 0 repeats on the first BURST cycle.
//  WAIT_RESP: 8-bit timer counts from 0.
//    route_error -> error path; route_ready -> capture resp_addr/resp_data, status 00.
//    Both asserted in one cycle: error wins.
//    Timer == TIMEOUT_CYCLES-1 with no pulse -> status 10.
//    Pulses outside WAIT_RESP are ignored.
//  DONE: done=1 for 1 cycle, tx_busy drops the same cycle, buffer count/wptr cleared, then IDLE.
//  Latency: accepted tx_start -> packet_send next cycle; last word at +PACKET_SIZE+1.
//  Reset mid-packet: immediate abort, outputs to reset values, buffer emptied, no done pulse.
// CONFIGURATION
//  IC_SENDER_RETRY_EN defined: on route_error with retry_cnt<MAX_RETRY, retry_cnt+1 and return to START.
//    Buffer contents are replayed unchanged.
//    Error with retry_cnt==MAX_RETRY -> DONE with status 01.
//    retry_cnt clears in DONE.
//  Undefined: route_error goes directly to DONE with status 01; no retry counter is built.
// STRUCTURE
//  Package ic_pkg: state encoding (3-bit localparams), status codes ST_OK/ST_ERR/ST_TIMEOUT, IC_WORD_W=32.
//  Sub-module ic_tx_buffer: PACKET_SIZE x 32 register file.
//    Write port carries wptr/count; read port is indexed.
//    It has a clear input and a full flag.
//  The top holds the FSM, timer, retry counter and response capture.
// TESTING
//  Load 8 words 0x10..0x17, tx_start, src 0xA000 dest 0xB000 -> packet_send 1 cycle, packet_data 0x10 x2 then 0x11..0x17.
//  Completing that packet: route_ready 3 cycles after the burst with routed_addr 0x400 -> done, status 00, resp_addr 0x400.
//  tx_start with only 5 words loaded -> ignored, tx_busy stays 0; 3 more loads then tx_start -> accepted.
//  No response -> done exactly TIMEOUT_CYCLES cycles after WAIT_RESP entry, status 10; buffer empty afterwards.
//  route_error and route_ready in the same cycle -> status 01 (macro off).
//  With the macro on, 2 errors then ready -> 3 bursts, status 00.
//  rst_n low during the 4th BURST word -> outputs 0 immediately, no done; load_ready=1 after release.

Source files
------------

// File: rtl/ic_pkg.sv
// ic_pkg: shared encodings for the interconnect packet sender.
// Holds the word width, the FSM state encoding and the completion status codes.
package ic_pkg;

  localparam int IC_WORD_W = 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BURST = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = S_IDLE,
    START     = S_START,
    BURST     = S_BURST,
    WAIT_RESP = S_WAIT,
    DONE      = S_DONE
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/ic_tx_buffer.sv
// ic_tx_buffer: DEPTH x IC_WORD_W register file that collects one packet.
// Sequential write port (write pointer + fill count), indexed read port,
// synchronous clear of the fill state and a full flag.
module ic_tx_buffer
  import ic_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     wr_en_i,
  input  logic [IC_WORD_W-1:0]     wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [IC_WORD_W-1:0]     rd_data_o,
  output logic                     full_o
);

  localparam int IdxW = $clog2(DEPTH);

  logic [IC_WORD_W-1:0] mem_q [DEPTH];
  logic [IdxW-1:0]      wptr_q;
  logic [IdxW:0]        count_q;

  assign full_o    = (count_q == (IdxW + 1)'(DEPTH));
  assign rd_data_o = mem_q[rd_idx_i];

  // Storage plus fill state; clear empties the buffer without touching the words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      wptr_q  <= '0;
      count_q <= '0;
    end else if (wr_en_i && !full_o) begin
      mem_q[wptr_q] <= wr_data_i;
      wptr_q        <= wptr_q + 1'b1;
      count_q       <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/interconnect_packet_sender.sv
// interconnect_packet_sender: buffers PACKET_SIZE words from a local producer,
// sends them to the interconnect router as one packet (strobe + word burst)
// and reports the router's completion status upstream.
// Optional feature: define IC_SENDER_RETRY_EN to resend the packet after
// route_error, up to MAX_RETRY times.
module interconnect_packet_sender
  import ic_pkg::*;
#(
  parameter int PACKET_SIZE    = 8,
  parameter int TIMEOUT_CYCLES = 64
`ifdef IC_SENDER_RETRY_EN
  ,
  parameter int MAX_RETRY      = 3
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [IC_WORD_W-1:0] load_data,
  input  logic                 tx_start,
  input  logic [IC_WORD_W-1:0] tx_src_addr,
  input  logic [IC_WORD_W-1:0] tx_dest_addr,
  output logic                 tx_busy,
  output logic                 packet_send,
  output logic [IC_WORD_W-1:0] src_addr,
  output logic [IC_WORD_W-1:0] dest_addr,
  output logic [IC_WORD_W-1:0] packet_data,
  input  logic                 route_ready,
  input  logic                 route_error,
  input  logic [IC_WORD_W-1:0] routed_addr,
  input  logic [IC_WORD_W-1:0] routed_data,
  output logic                 done,
  output logic [1:0]           done_status,
  output logic [IC_WORD_W-1:0] resp_addr,
  output logic [IC_WORD_W-1:0] resp_data
);

  localparam int IdxW = $clog2(PACKET_SIZE);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [7:0]           timer_q, timer_d;
  logic [IC_WORD_W-1:0] src_q, src_d, dest_q, dest_d;
  logic [IC_WORD_W-1:0] raddr_q, raddr_d, rdata_q, rdata_d;
  logic [1:0]           status_q, status_d;

  logic                 buf_full, buf_clear, buf_wr;
  logic [IdxW-1:0]      rd_idx;
  logic [IC_WORD_W-1:0] rd_word;

`ifdef IC_SENDER_RETRY_EN
  localparam int RetryW = $clog2(MAX_RETRY + 1);
  logic [RetryW-1:0]    retry_q, retry_d;
`endif

  // Loads are only taken while idle; reset forces the handshake low
  assign load_ready = rst_n && (state_q == IDLE) && !buf_full;
  assign buf_wr     = load_valid && load_ready;
  assign rd_idx     = (state_q == BURST) ? idx_q : '0;

  ic_tx_buffer #(
    .DEPTH (PACKET_SIZE)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (buf_clear),
    .wr_en_i   (buf_wr),
    .wr_data_i (load_data),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_word),
    .full_o    (buf_full)
  );

  assign packet_send = (state_q == START);
  assign packet_data = ((state_q == START) || (state_q == BURST)) ? rd_word : '0;
  assign tx_busy     = (state_q == START) || (state_q == BURST) || (state_q == WAIT_RESP);
  assign done        = (state_q == DONE);
  assign done_status = status_q;
  assign src_addr    = src_q;
  assign dest_addr   = dest_q;
  assign resp_addr   = raddr_q;
  assign resp_data   = rdata_q;

  // Next-state logic: packet sequencing, response timer, status and capture
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = '0;
    src_d     = src_q;
    dest_d    = dest_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    status_d  = status_q;
    buf_clear = 1'b0;
`ifdef IC_SENDER_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_start && buf_full) begin
          src_d   = tx_src_addr;
          dest_d  = tx_dest_addr;
          state_d = START;
        end
      end
      START: begin
        idx_d   = '0;
        state_d = BURST;
      end
      BURST: begin
        if (idx_q == IdxW'(PACKET_SIZE - 1)) begin
          state_d = WAIT_RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      WAIT_RESP: begin
        timer_d = timer_q + 8'd1;
        if (route_error) begin
`ifdef IC_SENDER_RETRY_EN
          if (retry_q < RetryW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = START;
          end else begin
            status_d = ST_ERR;
            state_d  = DONE;
          end
`else
          status_d = ST_ERR;
          state_d  = DONE;
`endif
        end else if (route_ready) begin
          raddr_d  = routed_addr;
          rdata_d  = routed_data;
          status_d = ST_OK;
          state_d  = DONE;
        end else if (timer_q == 8'(TIMEOUT_CYCLES - 1)) begin
          status_d = ST_TIMEOUT;
          state_d  = DONE;
        end
      end
      DONE: begin
        buf_clear = 1'b1;
        state_d   = IDLE;
`ifdef IC_SENDER_RETRY_EN
        retry_d   = '0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and held packet/response values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      timer_q  <= '0;
      src_q    <= '0;
      dest_q   <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      src_q    <= src_d;
      dest_q   <= dest_d;
      raddr_q  <= raddr_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
    end
  end

`ifdef IC_SENDER_RETRY_EN
  // Resend attempt counter for the packet in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

endmodule

// File: tb/tb_interconnect_packet_sender.sv
// tb_interconnect_packet_sender: directed plus randomized checks of the packet
// sender against a queue-based packet/response model.
`timescale 1ns/1ps
module tb_interconnect_packet_sender;

  localparam int PS = 8;
  localparam int TO = 64;
`ifdef IC_SENDER_RETRY_EN
  localparam int RETRY_LIMIT = 3;
`else
  localparam int RETRY_LIMIT = 0;
`endif
  localparam int K_READY   = 0;
  localparam int K_ERROR   = 1;
  localparam int K_BOTH    = 2;
  localparam int K_TIMEOUT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic        tx_start = 1'b0;
  logic [31:0] tx_src_addr = '0;
  logic [31:0] tx_dest_addr = '0;
  logic        tx_busy;
  logic        packet_send;
  logic [31:0] src_addr;
  logic [31:0] dest_addr;
  logic [31:0] packet_data;
  logic        route_ready = 1'b0;
  logic        route_error = 1'b0;
  logic [31:0] routed_addr = '0;
  logic [31:0] routed_data = '0;
  logic        done;
  logic [1:0]  done_status;
  logic [31:0] resp_addr;
  logic [31:0] resp_data;

  always #5 clk = ~clk;

  interconnect_packet_sender dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .tx_start     (tx_start),
    .tx_src_addr  (tx_src_addr),
    .tx_dest_addr (tx_dest_addr),
    .tx_busy      (tx_busy),
    .packet_send  (packet_send),
    .src_addr     (src_addr),
    .dest_addr    (dest_addr),
    .packet_data  (packet_data),
    .route_ready  (route_ready),
    .route_error  (route_error),
    .routed_addr  (routed_addr),
    .routed_data  (routed_data),
    .done         (done),
    .done_status  (done_status),
    .resp_addr    (resp_addr),
    .resp_data    (resp_data)
  );

  int          checkCount = 0;
  int          passCount = 0;
  int          failCount = 0;
  logic [31:0] modelBuf[$];
  logic [1:0]  lastStatus = 2'b00;
  logic [31:0] lastRespAddr = '0;
  logic [31:0] lastRespData = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount = passCount + 1;
    else begin
      failCount = failCount + 1;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [31:0] ld, input logic ts,
                               input logic rr, input logic re);
    load_valid  = lv;
    load_data   = ld;
    tx_start    = ts;
    route_ready = rr;
    route_error = re;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_load_ready"}, load_ready, 0);
    checkOutput({tag, "_tx_busy"}, tx_busy, 0);
    checkOutput({tag, "_packet_send"}, packet_send, 0);
    checkOutput({tag, "_packet_data"}, packet_data, 0);
    checkOutput({tag, "_src_addr"}, src_addr, 0);
    checkOutput({tag, "_dest_addr"}, dest_addr, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_done_status"}, done_status, 0);
    checkOutput({tag, "_resp_addr"}, resp_addr, 0);
    checkOutput({tag, "_resp_data"}, resp_data, 0);
  endtask

  // Offer n words; the model accepts a word only while fewer than PS are held
  task automatic loadWords(input int n, input logic [31:0] base, input bit randomData);
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      w = randomData ? $urandom : base + 32'(k);
      repeat ($urandom_range(0, 1)) begin
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        tick();
      end
      applyStimulus(1'b1, w, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("load_ready_w%0d", modelBuf.size()), load_ready, 32'(modelBuf.size() < PS));
      tick();
      if (modelBuf.size() < PS) modelBuf.push_back(w);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Pulse tx_start for one cycle; it takes effect only with a full buffer
  task automatic startPacket(input logic [31:0] src, input logic [31:0] dest);
    bit expAccept;
    expAccept    = (modelBuf.size() == PS);
    tx_src_addr  = src;
    tx_dest_addr = dest;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("start_tx_busy", tx_busy, 32'(expAccept));
    checkOutput("start_packet_send", packet_send, 32'(expAccept));
  endtask

  // Called in the strobe cycle; returns on the first response-wait cycle
  task automatic checkBurst(input logic [31:0] src, input logic [31:0] dest);
    checkOutput("strobe", packet_send, 1);
    checkOutput("strobe_word", packet_data, modelBuf[0]);
    checkOutput("strobe_src", src_addr, src);
    checkOutput("strobe_dest", dest_addr, dest);
    checkOutput("strobe_load_ready", load_ready, 0);
    for (int i = 0; i < PS; i++) begin
      tick();
      checkOutput($sformatf("burst_send_low%0d", i), packet_send, 0);
      checkOutput($sformatf("burst_word%0d", i), packet_data, modelBuf[i]);
    end
    tick();
  endtask

  // Burst(s) plus response handling; errs leading errors precede the final kind
  task automatic runResponse(input logic [31:0] src, input logic [31:0] dest, input int kind,
                             input int errs, input int delay, input logic [31:0] rAddr);
    int         used;
    int         pk;
    logic [1:0] expStatus;
    logic [31:0] rData;
    used = 0;
    for (int attempt = 0; attempt < 8; attempt++) begin
      checkBurst(src, dest);
      pk = (attempt < errs) ? K_ERROR : kind;
      if (pk == K_TIMEOUT) begin
        repeat (TO - 1) tick();
        checkOutput("timeout_not_yet", done, 0);
        checkOutput("timeout_busy", tx_busy, 1);
        tick();
        expStatus = 2'b10;
      end else begin
        repeat (delay) tick();
        checkOutput("wait_no_done", done, 0);
        rData       = $urandom;
        routed_addr = rAddr;
        routed_data = rData;
        applyStimulus(1'b0, '0, 1'b0, pk != K_ERROR, pk != K_READY);
        tick();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        if (pk != K_READY && used < RETRY_LIMIT) begin
          used++;
          continue;
        end
        if (pk == K_READY) begin
          expStatus    = 2'b00;
          lastRespAddr = rAddr;
          lastRespData = rData;
        end else begin
          expStatus = 2'b01;
        end
      end
      lastStatus = expStatus;
      checkOutput("done_pulse", done, 1);
      checkOutput("done_status", done_status, expStatus);
      checkOutput("done_tx_busy", tx_busy, 0);
      checkOutput("done_resp_addr", resp_addr, lastRespAddr);
      checkOutput("done_resp_data", resp_data, lastRespData);
      checkOutput("done_src_held", src_addr, src);
      tick();
      modelBuf.delete();
      checkOutput("after_done_low", done, 0);
      checkOutput("after_status_held", done_status, lastStatus);
      checkOutput("after_load_ready", load_ready, 1);
      return;
    end
  endtask

  initial begin
    logic [31:0] s;
    logic [31:0] d;

    // Reset values while held and after release
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #12;
    checkResetOutputs("reset");
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("release_load_ready", load_ready, 1);

    // Directed packet 0x10..0x17, success after 3 wait cycles
    loadWords(PS, 32'h10, 1'b0);
    startPacket(32'hA000, 32'hB000);
    runResponse(32'hA000, 32'hB000, K_READY, 0, 3, 32'h400);

    // Start with 5 words is ignored; load plus start in one cycle only loads
    loadWords(5, '0, 1'b1);
    startPacket(32'h1, 32'h2);
    loadWords(2, '0, 1'b1);
    s = $urandom;
    applyStimulus(1'b1, s, 1'b1, 1'b0, 1'b0);
    checkOutput("same_cycle_load_ready", load_ready, 1);
    tick();
    modelBuf.push_back(s);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("same_cycle_not_busy", tx_busy, 0);
    s = $urandom;
    d = $urandom;
    startPacket(s, d);
    runResponse(s, d, K_READY, 0, $urandom_range(0, 10), $urandom);

    // Router pulses while idle are ignored
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_pulse_no_done", done, 0);
    checkOutput("idle_pulse_status", done_status, lastStatus);

    // Timeout, then simultaneous error+ready, then plain error
    loadWords(PS, '0, 1'b1);
    startPacket(32'hC0, 32'hD0);
    runResponse(32'hC0, 32'hD0, K_TIMEOUT, 0, 0, '0);
    loadWords(PS, '0, 1'b1);
    startPacket(32'hC1, 32'hD1);
    runResponse(32'hC1, 32'hD1, K_BOTH, 0, 2, 32'h77);
    loadWords(PS, '0, 1'b1);
    startPacket(32'hC2, 32'hD2);
    runResponse(32'hC2, 32'hD2, K_ERROR, 0, 0, 32'h78);

    // Two errors then ready
    loadWords(PS, '0, 1'b1);
    startPacket(32'hC3, 32'hD3);
    runResponse(32'hC3, 32'hD3, K_READY, 2, 1, 32'h500);

    // Randomized packets
    for (int p = 0; p < 5; p++) begin
      s = $urandom;
      d = $urandom;
      loadWords(PS, '0, 1'b1);
      startPacket(s, d);
      runResponse(s, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 20), $urandom);
    end

    // Reset during the 4th burst word aborts without a done pulse
    loadWords(PS, '0, 1'b1);
    startPacket(32'hE0, 32'hF0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("abort_word3", packet_data, modelBuf[3]);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("abort");
    modelBuf.delete();
    lastStatus   = 2'b00;
    lastRespAddr = '0;
    lastRespData = '0;
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("abort_release_load_ready", load_ready, 1);
    checkOutput("abort_release_done", done, 0);
    loadWords(PS, '0, 1'b1);
    startPacket(32'hE1, 32'hF1);
    runResponse(32'hE1, 32'hF1, K_READY, 0, 4, 32'h600);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
